imem_boot_arbiter: RTL

//  Owns the single port of the instruction memory and shares it between the program loader
//  (word-stream writes) and the fetch stage (PC-addressed reads).

---
 rtl/imem_boot_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/imem_boot_arbiter.sv
// Instruction-memory port arbiter: streams a boot image from the loader, then hands the port to fetch.
// Optional image checksum check is enabled with `define IMEM_BOOT_CHECKSUM_EN.
module imem_boot_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int BOOT_WORDS   = 32,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic [DATA_WIDTH-1:0] ld_checksum,
  output logic                  ld_ready,
  input  logic                  reload_req,
  input  logic [31:0]           pc_f,
  output logic [31:0]           mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  stall_f,
  output logic                  core_rst,
  output logic [ADDR_WIDTH:0]   load_cnt,
  output logic                  err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(BOOT_WORDS - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            accept;
  logic            done;
  logic            clr_sum;
  logic            sum_ok;

  assign accept   = (state_q == S_LOAD) && ld_valid;
  // The index bound and ld_last may coincide; either alone closes the image exactly once.
  assign done     = accept && (ld_last || (cnt_q == LAST_IDX));
  assign load_cnt = cnt_q;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // The final word is still in flight at completion, so it is folded in here.
  assign sum_ok = (sum_q + ld_data) == ld_checksum;

  always_comb begin
    sum_d = sum_q;
    if (clr_sum) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`else
  logic unused_checksum;
  assign sum_ok          = 1'b1;
  assign unused_checksum = ^{ld_checksum, clr_sum};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    clr_sum  = 1'b0;
    ld_ready = 1'b0;
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    stall_f  = 1'b1;
    core_rst = 1'b1;
    err      = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        ld_ready = 1'b1;
        mem_addr = 32'({cnt_q, 2'b00});
        mem_wd   = ld_data;
        mem_we   = ld_valid;
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (done) begin
          state_d = sum_ok ? S_START : S_ERROR;
        end
      end

      S_START: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        mem_addr = pc_f;
        stall_f  = 1'b0;
        core_rst = 1'b0;
        if (reload_req) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end

      // Pipeline keeps running (not in reset) but fetch is frozen until it empties.
      S_DRAIN: begin
        mem_addr = pc_f;
        core_rst = 1'b0;
        dcnt_d   = dcnt_q + DW'(1);
        if (dcnt_q == DRAIN_END) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          clr_sum = 1'b1;
        end
      end

      S_ERROR: begin
        err = 1'b1;
        if (reload_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          clr_sum = 1'b1;
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

endmodule
